zion_clr_rap_reg_arb: RTL and testbench

- Shares one clearable, reset-as-preset data register between NUM_REQ requesters.
- Each requester either writes a new value or clears the register back to INI_DATA.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Sits in front of state registers that several agents update, e.g. config/status words owned by multiple pipeline stages.

---
 rtl/zion_clr_rap_reg_arb.sv | 85 ++++++++
 tb/tb_zion_clr_rap_reg_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/zion_clr_rap_reg_arb.sv
// Round-robin arbitrated shared register: each requester writes data or clears it back to INI_DATA.
// Optional ZION_CLR_RAP_REG_ARB_CLR_PRIO_EN gives clear requests strict priority over writes.
module zion_clr_rap_reg_arb #(
    parameter int                NUM_REQ  = 4,
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  INI_DATA = 32'h1,
    localparam int               ID_W     = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       iHold,
    input  logic [NUM_REQ-1:0]         iReqVld,
    input  logic [NUM_REQ-1:0]         iReqClr,
    input  logic [NUM_REQ*WIDTH-1:0]   iReqDat,
    output logic [NUM_REQ-1:0]         oReqRdy,
    output logic [WIDTH-1:0]           oDat,
    output logic                       oUpdVld,
    output logic [ID_W-1:0]            oUpdId,
    output logic                       oUpdClr
);

    // Handshake: requester k transfers on a rising edge where iReqVld[k] & oReqRdy[k];
    // the requester keeps valid/type/data stable until then, oReqRdy is one-hot or zero.

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic               gnt_clr;
    logic [WIDTH-1:0]   gnt_dat;

    always_comb begin
`ifdef ZION_CLR_RAP_REG_ARB_CLR_PRIO_EN
        // Any pending clear restricts the round-robin to clear requesters only.
        cand = (|(iReqVld & iReqClr)) ? (iReqVld & iReqClr) : iReqVld;
`else
        cand = iReqVld;
`endif
    end

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        if (rst_n && !iHold) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(ptr) + i) % NUM_REQ;
                if (!gnt_any && cand[idx]) begin
                    gnt_any  = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_clr = iReqClr[gnt_id];
        gnt_dat = iReqDat[int'(gnt_id)*WIDTH +: WIDTH];
        oReqRdy = gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            oDat    <= INI_DATA;
            oUpdVld <= 1'b0;
            oUpdId  <= '0;
            oUpdClr <= 1'b0;
        end else begin
            oUpdVld <= 1'b0;
            if (gnt_any) begin
                oDat    <= gnt_clr ? INI_DATA : gnt_dat;
                oUpdVld <= 1'b1;
                oUpdId  <= gnt_id;
                oUpdClr <= gnt_clr;
                ptr     <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_zion_clr_rap_reg_arb.sv
// Scoreboard bench for zion_clr_rap_reg_arb: a reference arbiter predicts grants and updates,
// a monitor compares every cycle's register outputs against the expected queue.
module tb_zion_clr_rap_reg_arb;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int ID_W = $clog2(N);
    localparam int EW   = W + ID_W + 1;
    localparam logic [W-1:0] INI = 32'h1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             iHold = 1'b0;
    logic [N-1:0]     iReqVld = '0;
    logic [N-1:0]     iReqClr = '0;
    logic [N*W-1:0]   iReqDat = '0;
    logic [N-1:0]     oReqRdy;
    logic [W-1:0]     oDat;
    logic             oUpdVld;
    logic [ID_W-1:0]  oUpdId;
    logic             oUpdClr;

    zion_clr_rap_reg_arb #(.NUM_REQ(N), .WIDTH(W), .INI_DATA(INI)) dut (
        .clk(clk), .rst_n(rst_n), .iHold(iHold),
        .iReqVld(iReqVld), .iReqClr(iReqClr), .iReqDat(iReqDat),
        .oReqRdy(oReqRdy), .oDat(oDat), .oUpdVld(oUpdVld),
        .oUpdId(oUpdId), .oUpdClr(oUpdClr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // requester-side model state
    bit             vld_m [N];
    bit             clr_m [N];
    logic [W-1:0]   dat_m [N];
    bit             hold_m = 1'b0;
    bit             sticky = 1'b0;
    int             m_ptr = 0;

    // scoreboard
    logic [EW-1:0]   exp_q[$];
    logic [W-1:0]    exp_dat = INI;
    logic [ID_W-1:0] exp_id  = '0;
    logic            exp_clr = 1'b0;

    function automatic int model_pick();
        bit clr_pending;
        int k;
        clr_pending = 1'b0;
        if (!rst_n || hold_m) return -1;
`ifdef ZION_CLR_RAP_REG_ARB_CLR_PRIO_EN
        for (int j = 0; j < N; j++) if (vld_m[j] && clr_m[j]) clr_pending = 1'b1;
`endif
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (vld_m[k] && (!clr_pending || clr_m[k])) return k;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            iReqVld[k]         = vld_m[k];
            iReqClr[k]         = clr_m[k];
            iReqDat[k*W +: W]  = dat_m[k];
        end
        iHold = hold_m;
    endtask

    task automatic eval_grant();
        int g;
        logic [N-1:0] exp_rdy;
        g = model_pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("grant", 64'(oReqRdy), 64'(exp_rdy));
        if (g >= 0) begin
            exp_q.push_back({ID_W'(g), clr_m[g], clr_m[g] ? INI : dat_m[g]});
            m_ptr = (g + 1) % N;
            if (!sticky) vld_m[g] = 1'b0;
        end
    endtask

    // driver: inputs change just after posedge, grant checked just after negedge
    task automatic cycle();
        apply();
        @(negedge clk); #1;
        eval_grant();
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin vld_m[k] = 1'b0; clr_m[k] = 1'b0; dat_m[k] = '0; end
        hold_m = 1'b0;
        sticky = 1'b0;
    endtask

    task automatic req(input int k, input bit clr, input logic [W-1:0] d);
        vld_m[k] = 1'b1; clr_m[k] = clr; dat_m[k] = d;
    endtask

    task automatic rand_cycle();
        hold_m = ($urandom_range(0, 9) == 0);
        for (int k = 0; k < N; k++)
            if (!vld_m[k] && $urandom_range(0, 2) == 0)
                req(k, $urandom_range(0, 3) == 0, $urandom);
        cycle();
    endtask

    task automatic reset_mid();
        apply();
        @(negedge clk); #1;
        eval_grant();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_dat", 64'(oDat), 64'(INI));
        check("async_rst_upd", 64'(oUpdVld), 64'd0);
        check("async_rst_rdy", 64'(oReqRdy), 64'd0);
        exp_q.delete();
        exp_dat = INI; exp_id = '0; exp_clr = 1'b0;
        m_ptr = 0;
        rst_n = 1'b1;
        #1;
        eval_grant();
        @(posedge clk); #1;
    endtask

    // monitor: every negedge, pop the update due this cycle or confirm outputs hold
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_dat = e[W-1:0];
                exp_clr = e[W];
                exp_id  = e[W+1 +: ID_W];
                check("upd_vld", 64'(oUpdVld), 64'd1);
                check("upd_id", 64'(oUpdId), 64'(exp_id));
                check("upd_clr", 64'(oUpdClr), 64'(exp_clr));
            end else begin
                check("upd_idle", 64'(oUpdVld), 64'd0);
                check("upd_id_hold", 64'(oUpdId), 64'(exp_id));
                check("upd_clr_hold", 64'(oUpdClr), 64'(exp_clr));
            end
            check("dat", 64'(oDat), 64'(exp_dat));
        end
    end

    initial begin
        idle_all();
        // reset with no requests
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // single write by requester 2
        req(2, 1'b0, 32'hDEAD_BEEF);
        cycle();
        cycle();
        // requester 3 alone brings the pointer back to 0
        req(3, 1'b0, 32'h33);
        cycle();

        // all four writing continuously: expect 0,1,2,3,0
        sticky = 1'b1;
        for (int k = 0; k < N; k++) req(k, 1'b0, 32'h10 + k);
        repeat (5) cycle();
        idle_all();

        // load 0x55, then a clear held off by iHold
        req(0, 1'b0, 32'h55);
        cycle();
        req(1, 1'b1, 32'hFFFF_0000);
        hold_m = 1'b1;
        repeat (3) cycle();
        hold_m = 1'b0;
        repeat (2) cycle();

        // write and clear arriving together with pointer at 0
        req(3, 1'b0, 32'h77);
        cycle();
        req(0, 1'b0, 32'hAA);
        req(3, 1'b1, 32'h0);
        repeat (3) cycle();

        // two clears in a row: the second one lands on INI_DATA and still pulses
        req(2, 1'b1, 32'h0);
        cycle();
        req(2, 1'b1, 32'h0);
        repeat (2) cycle();

        // randomized traffic
        repeat (400) rand_cycle();
        idle_all();
        repeat (2) cycle();

        // asynchronous reset in the middle of continuous writes
        sticky = 1'b1;
        for (int k = 0; k < N; k++) req(k, 1'b0, $urandom);
        repeat (3) cycle();
        reset_mid();
        repeat (4) cycle();
        idle_all();
        repeat (2) cycle();

        repeat (300) rand_cycle();
        idle_all();
        repeat (3) cycle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
